// File: rtl/pong_collision.sv
`default_nettype none
// ============================================================================
//  Module   : pong_collision
//  Purpose  : Collision and miss referee for the Pong datapath. Once per
//             frame it checks the ball against both paddles and the
//             top/bottom walls. It emits single-cycle bounce pulses, using a
//             lockout so that each contact reverses the ball exactly once.
//             It also detects misses, holds play for HOLD_FRAMES frames and
//             then requests a re-serve.
//  Ports    : clk, reset (sync, active-high), frame_tick (frame strobe),
//             ball_x/ball_y (ball top-left), lpad_y/rpad_y (paddle tops),
//             touching_paddle/touching_wall (bounce pulses),
//             miss_left/miss_right (miss pulses), serve (re-serve pulse),
//             in_play, score_l/score_r, game_over
//  Options  : define SCORE_EN to enable the score counters and end-of-game
//             detection. Without it, scores and game_over are tied to 0.
//  Revision : 1.0 - initial release
// ============================================================================
module pong_collision #(
   parameter int X_W         = 10,
   parameter int Y_W         = 10,
   parameter int SCREEN_W    = 640,
   parameter int SCREEN_H    = 480,
   parameter int BALL_SIZE   = 10,
   parameter int PADDLE_W    = 10,
   parameter int PADDLE_H    = 80,
   parameter int LPAD_X      = 20,
   parameter int RPAD_X      = 610,
   parameter int WALL_MARGIN = 10,
   parameter int HOLD_FRAMES = 60,
   parameter int SCORE_W     = 4,
   parameter int WIN_SCORE   = 9
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               frame_tick,
   input  logic [X_W-1:0]     ball_x,
   input  logic [Y_W-1:0]     ball_y,
   input  logic [Y_W-1:0]     lpad_y,
   input  logic [Y_W-1:0]     rpad_y,
   output logic               touching_paddle,
   output logic               touching_wall,
   output logic               miss_left,
   output logic               miss_right,
   output logic               serve,
   output logic               in_play,
   output logic [SCORE_W-1:0] score_l,
   output logic [SCORE_W-1:0] score_r,
   output logic               game_over
);

   // One spare bit so that coordinate + size never wraps.
   localparam int c_GW     = ((X_W > Y_W) ? X_W : Y_W) + 1;
   localparam int c_HOLD_W = (HOLD_FRAMES < 2) ? 1 : $clog2(HOLD_FRAMES + 1);

   localparam logic [c_HOLD_W-1:0] c_HOLD_LOAD = c_HOLD_W'(HOLD_FRAMES);
   localparam logic [c_HOLD_W-1:0] c_HOLD_ONE  = c_HOLD_W'(1);
   localparam logic [SCORE_W-1:0]  c_SCORE_MAX = '1;

   localparam logic [c_GW-1:0] c_LPAD_L   = c_GW'(LPAD_X);
   localparam logic [c_GW-1:0] c_LPAD_R   = c_GW'(LPAD_X + PADDLE_W);
   localparam logic [c_GW-1:0] c_RPAD_L   = c_GW'(RPAD_X);
   localparam logic [c_GW-1:0] c_RPAD_R   = c_GW'(RPAD_X + PADDLE_W);
   localparam logic [c_GW-1:0] c_SCREEN_W = c_GW'(SCREEN_W);
   localparam logic [c_GW-1:0] c_SCREEN_H = c_GW'(SCREEN_H);
   localparam logic [c_GW-1:0] c_WALL_TOP = c_GW'(WALL_MARGIN);
   localparam logic [c_GW-1:0] c_WALL_BOT = c_GW'(SCREEN_H - WALL_MARGIN);
   localparam logic [c_GW-1:0] c_BALL     = c_GW'(BALL_SIZE);
   localparam logic [c_GW-1:0] c_PAD_H    = c_GW'(PADDLE_H);

`ifdef SCORE_EN
   localparam bit c_SCORE_ON = 1'b1;
`else
   localparam bit c_SCORE_ON = 1'b0;
`endif

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_SERVE = 3'd1,
      S_PLAY  = 3'd2,
      S_HOLD  = 3'd3,
      S_OVER  = 3'd4
   } state_t;

   state_t               r_state, w_state_next;
   logic [c_HOLD_W-1:0]  r_hold, w_hold_next;
   logic                 r_paddle_lock, w_paddle_lock_next;
   logic                 r_wall_lock, w_wall_lock_next;
   logic                 r_tp, w_tp_next;
   logic                 r_tw, w_tw_next;
   logic                 r_ml, w_ml_next;
   logic                 r_mr, w_mr_next;
   logic [SCORE_W-1:0]   r_score_l, w_score_l_next;
   logic [SCORE_W-1:0]   r_score_r, w_score_r_next;
   logic                 r_game_over, w_game_over_next;

   // ---------------------------------------------------------------- geometry
   logic [c_GW-1:0] w_bx, w_by, w_ly, w_ry;
   logic [c_GW-1:0] w_bx_end, w_by_end, w_ly_end, w_ry_end;
   logic            w_lhit, w_rhit, w_pad, w_wall, w_offl, w_offr;
   logic            w_miss_l, w_miss_r;

   assign w_bx     = c_GW'(ball_x);
   assign w_by     = c_GW'(ball_y);
   assign w_ly     = c_GW'(lpad_y);
   assign w_ry     = c_GW'(rpad_y);
   assign w_bx_end = w_bx + c_BALL;
   assign w_by_end = w_by + c_BALL;
   assign w_ly_end = w_ly + c_PAD_H;
   assign w_ry_end = w_ry + c_PAD_H;

   assign w_lhit = (w_bx <= c_LPAD_R) && (w_bx_end >= c_LPAD_L) &&
                   (w_by_end >= w_ly) && (w_by <= w_ly_end);
   assign w_rhit = (w_bx <= c_RPAD_R) && (w_bx_end >= c_RPAD_L) &&
                   (w_by_end >= w_ry) && (w_by <= w_ry_end);
   assign w_pad  = w_lhit || w_rhit;

   // A ball that moved up past row 0 wraps to a large y, hence the last term.
   assign w_wall = (w_by <= c_WALL_TOP) || (w_by_end >= c_WALL_BOT) ||
                   (w_by >= c_SCREEN_H);

   // Likewise an x underflow past 0 shows up as x >= SCREEN_W: off-left.
   assign w_offl = (w_bx_end < c_LPAD_L) || (w_bx >= c_SCREEN_W);
   assign w_offr = (w_bx > c_RPAD_R) && (w_bx < c_SCREEN_W);

   // Any paddle overlap beats a miss.
   assign w_miss_l = w_offl && !w_lhit;
   assign w_miss_r = w_offr && !w_rhit;

   // ------------------------------------------------------- next-state logic
   always_comb begin
      w_state_next       = r_state;
      w_hold_next        = r_hold;
      w_paddle_lock_next = r_paddle_lock;
      w_wall_lock_next   = r_wall_lock;
      w_tp_next          = 1'b0;
      w_tw_next          = 1'b0;
      w_ml_next          = 1'b0;
      w_mr_next          = 1'b0;
      w_score_l_next     = r_score_l;
      w_score_r_next     = r_score_r;
      w_game_over_next   = r_game_over;

      case (r_state)
         S_IDLE: begin
            if (frame_tick) w_state_next = S_SERVE;
         end
         S_SERVE: begin
            w_paddle_lock_next = 1'b0;
            w_wall_lock_next   = 1'b0;
            w_state_next       = S_PLAY;
         end
         S_PLAY: begin
            if (frame_tick) begin
               if (w_miss_l || w_miss_r) begin
                  // Bounce pulses are suppressed on the tick that scores.
                  w_ml_next    = w_miss_l;
                  w_mr_next    = w_miss_r;
                  w_hold_next  = c_HOLD_LOAD;
                  w_state_next = S_HOLD;
                  if (c_SCORE_ON) begin
                     if (w_miss_l && (r_score_r != c_SCORE_MAX))
                        w_score_r_next = r_score_r + 1'b1;
                     if (w_miss_r && (r_score_l != c_SCORE_MAX))
                        w_score_l_next = r_score_l + 1'b1;
                     w_game_over_next = r_game_over ||
                                        (int'(w_score_l_next) >= WIN_SCORE) ||
                                        (int'(w_score_r_next) >= WIN_SCORE);
                  end
               end else begin
                  // A lock stays set while contact persists and clears on
                  // the first tick without contact.
                  w_tp_next          = w_pad && !r_paddle_lock;
                  w_paddle_lock_next = w_pad;
                  w_tw_next          = w_wall && !r_wall_lock;
                  w_wall_lock_next   = w_wall;
               end
            end
         end
         S_HOLD: begin
            if (frame_tick) begin
               // The tick that takes the counter to zero ends the hold.
               if (r_hold <= c_HOLD_ONE) begin
                  w_hold_next  = '0;
                  w_state_next = r_game_over ? S_OVER : S_SERVE;
               end else begin
                  w_hold_next = r_hold - 1'b1;
               end
            end
         end
         S_OVER: begin
            w_state_next = S_OVER;
         end
         default: begin
            w_state_next = S_IDLE;
         end
      endcase
   end

   // ------------------------------------------------------------- registers
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state       <= S_IDLE;
         r_hold        <= '0;
         r_paddle_lock <= 1'b0;
         r_wall_lock   <= 1'b0;
         r_tp          <= 1'b0;
         r_tw          <= 1'b0;
         r_ml          <= 1'b0;
         r_mr          <= 1'b0;
         r_score_l     <= '0;
         r_score_r     <= '0;
         r_game_over   <= 1'b0;
      end else begin
         r_state       <= w_state_next;
         r_hold        <= w_hold_next;
         r_paddle_lock <= w_paddle_lock_next;
         r_wall_lock   <= w_wall_lock_next;
         r_tp          <= w_tp_next;
         r_tw          <= w_tw_next;
         r_ml          <= w_ml_next;
         r_mr          <= w_mr_next;
         r_score_l     <= w_score_l_next;
         r_score_r     <= w_score_r_next;
         r_game_over   <= w_game_over_next;
      end
   end

   assign touching_paddle = r_tp;
   assign touching_wall   = r_tw;
   assign miss_left       = r_ml;
   assign miss_right      = r_mr;
   assign serve           = (r_state == S_SERVE);
   assign in_play         = (r_state == S_PLAY);
   assign score_l         = r_score_l;
   assign score_r         = r_score_r;
   assign game_over       = r_game_over;

endmodule
`default_nettype wire

// File: tb/tb_pong_collision.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pong_collision
//  Purpose  : Self-checking bench for pong_collision. Expected outputs are
//             queued as each cycle's stimulus is driven and compared on the
//             following falling edge, after the registered outputs settle.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_pong_collision;

`ifdef SCORE_EN
   localparam bit SC = 1'b1;
`else
   localparam bit SC = 1'b0;
`endif

   logic       clk;
   logic       reset;
   logic       frame_tick;
   logic [9:0] ball_x, ball_y, lpad_y, rpad_y;
   logic       touching_paddle, touching_wall, miss_left, miss_right;
   logic       serve, in_play, game_over;
   logic [3:0] score_l, score_r;

   pong_collision #(
      .HOLD_FRAMES (3),
      .WIN_SCORE   (2)
   ) dut (
      .clk             (clk),
      .reset           (reset),
      .frame_tick      (frame_tick),
      .ball_x          (ball_x),
      .ball_y          (ball_y),
      .lpad_y          (lpad_y),
      .rpad_y          (rpad_y),
      .touching_paddle (touching_paddle),
      .touching_wall   (touching_wall),
      .miss_left       (miss_left),
      .miss_right      (miss_right),
      .serve           (serve),
      .in_play         (in_play),
      .score_l         (score_l),
      .score_r         (score_r),
      .game_over       (game_over)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic       tp, tw, ml, mr, sv, ip;
      logic [3:0] sl, sr;
      logic       go;
   } exp_t;

   typedef struct packed {
      logic       t;
      logic [9:0] bx, by, ly, ry;
      logic       tp, tw;
   } vec_t;

   exp_t  exp_q[$];
   string tag_q[$];
   int    checks   = 0;
   int    failures = 0;
   vec_t  vt[16];

   function automatic exp_t mk(input logic tp, tw, ml, mr, sv, ip,
                               input int sl, sr, input logic go);
      exp_t e;
      e.tp = tp; e.tw = tw; e.ml = ml; e.mr = mr; e.sv = sv; e.ip = ip;
      e.sl = 4'(sl); e.sr = 4'(sr); e.go = go;
      return e;
   endfunction

   function automatic int scv(input int n);
      return SC ? n : 0;
   endfunction

   // One clock of stimulus starting on a falling edge; the outcome is
   // compared on the next falling edge.
   task automatic cyc(input logic r, input logic t,
                      input logic [9:0] bx, by, ly, ry,
                      input exp_t e, input string tag);
      exp_t exp_v, act;
      string tg;
      reset = r; frame_tick = t;
      ball_x = bx; ball_y = by; lpad_y = ly; rpad_y = ry;
      exp_q.push_back(e);
      tag_q.push_back(tag);
      @(negedge clk);
      frame_tick = 1'b0;
      reset = 1'b0;
      exp_v = exp_q.pop_front();
      tg    = tag_q.pop_front();
      act = {touching_paddle, touching_wall, miss_left, miss_right,
             serve, in_play, score_l, score_r, game_over};
      checks++;
      if (act !== exp_v) begin
         failures++;
         $display("FAIL %s: got tp/tw/ml/mr/sv/ip=%b sl=%0d sr=%0d go=%b, want tp/tw/ml/mr/sv/ip=%b sl=%0d sr=%0d go=%b",
                  tg, act[14:9], act[8:5], act[4:1], act[0],
                  exp_v[14:9], exp_v[8:5], exp_v[4:1], exp_v[0]);
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      //       tick  bx       by       ly       ry       tp    tw
      vt[0]  = {1'b1, 10'd25,  10'd200, 10'd160, 10'd0,   1'b1, 1'b0};
      vt[1]  = {1'b1, 10'd25,  10'd200, 10'd160, 10'd0,   1'b0, 1'b0};
      vt[2]  = {1'b1, 10'd100, 10'd200, 10'd160, 10'd0,   1'b0, 1'b0};
      vt[3]  = {1'b1, 10'd25,  10'd200, 10'd160, 10'd0,   1'b1, 1'b0};
      vt[4]  = {1'b1, 10'd300, 10'd5,   10'd160, 10'd0,   1'b0, 1'b1};
      vt[5]  = {1'b1, 10'd300, 10'd5,   10'd160, 10'd0,   1'b0, 1'b0};
      vt[6]  = {1'b1, 10'd300, 10'd200, 10'd160, 10'd0,   1'b0, 1'b0};
      vt[7]  = {1'b1, 10'd25,  10'd5,   10'd0,   10'd0,   1'b1, 1'b1};
      vt[8]  = {1'b1, 10'd100, 10'd200, 10'd160, 10'd0,   1'b0, 1'b0};
      vt[9]  = {1'b1, 10'd605, 10'd200, 10'd160, 10'd160, 1'b1, 1'b0};
      vt[10] = {1'b1, 10'd300, 10'd460, 10'd160, 10'd160, 1'b0, 1'b1};
      vt[11] = {1'b1, 10'd300, 10'd11,  10'd160, 10'd160, 1'b0, 1'b0};
      vt[12] = {1'b1, 10'd300, 10'd10,  10'd160, 10'd160, 1'b0, 1'b1};
      vt[13] = {1'b1, 10'd300, 10'd200, 10'd160, 10'd160, 1'b0, 1'b0};
      vt[14] = {1'b0, 10'd25,  10'd200, 10'd160, 10'd0,   1'b0, 1'b0};
      vt[15] = {1'b1, 10'd25,  10'd200, 10'd160, 10'd0,   1'b1, 1'b0};

      reset = 1'b1; frame_tick = 1'b0;
      ball_x = '0; ball_y = '0; lpad_y = '0; rpad_y = '0;
      @(negedge clk);
      @(negedge clk);

      // Reset state, frozen IDLE, first serve.
      cyc(1, 0, 0, 0, 0, 0, mk(0,0,0,0,0,0,0,0,0), "reset_state");
      cyc(0, 0, 25, 200, 160, 0, mk(0,0,0,0,0,0,0,0,0), "idle_no_tick");
      cyc(0, 1, 300, 200, 160, 0, mk(0,0,0,0,1,0,0,0,0), "first_serve");
      cyc(0, 0, 300, 200, 160, 0, mk(0,0,0,0,0,1,0,0,0), "enter_play");

      // Collision vectors in PLAY.
      for (int i = 0; i < 16; i++)
         cyc(0, vt[i].t, vt[i].bx, vt[i].by, vt[i].ly, vt[i].ry,
             mk(vt[i].tp, vt[i].tw, 0, 0, 0, 1, 0, 0, 0),
             $sformatf("vec%0d", i));

      // Wrapped off-left miss, then a 3-frame hold with the ball overlapping.
      cyc(0, 1, 1020, 200, 300, 0, mk(0,0,1,0,0,0,0,scv(1),0), "miss_left");
      cyc(0, 1, 25, 5, 0, 0, mk(0,0,0,0,0,0,0,scv(1),0), "hold_tick1");
      cyc(0, 0, 25, 5, 0, 0, mk(0,0,0,0,0,0,0,scv(1),0), "hold_no_tick");
      cyc(0, 1, 25, 5, 0, 0, mk(0,0,0,0,0,0,0,scv(1),0), "hold_tick2");
      cyc(0, 1, 25, 5, 0, 0, mk(0,0,0,0,1,0,0,scv(1),0), "hold_tick3_serve");
      cyc(0, 0, 630, 200, 160, 0, mk(0,0,0,0,0,1,0,scv(1),0), "replay1");

      // Two right misses; with scoring this ends the game.
      cyc(0, 1, 630, 200, 160, 0, mk(0,0,0,1,0,0,scv(1),scv(1),0), "miss_right1");
      cyc(0, 1, 630, 200, 160, 0, mk(0,0,0,0,0,0,scv(1),scv(1),0), "r1_hold1");
      cyc(0, 1, 630, 200, 160, 0, mk(0,0,0,0,0,0,scv(1),scv(1),0), "r1_hold2");
      cyc(0, 1, 630, 200, 160, 0, mk(0,0,0,0,1,0,scv(1),scv(1),0), "r1_serve");
      cyc(0, 0, 630, 200, 160, 0, mk(0,0,0,0,0,1,scv(1),scv(1),0), "replay2");
      cyc(0, 1, 630, 200, 160, 0, mk(0,0,0,1,0,0,scv(2),scv(1),SC), "miss_right2");
      cyc(0, 1, 300, 200, 160, 0, mk(0,0,0,0,0,0,scv(2),scv(1),SC), "r2_hold1");
      cyc(0, 1, 300, 200, 160, 0, mk(0,0,0,0,0,0,scv(2),scv(1),SC), "r2_hold2");
      cyc(0, 1, 300, 200, 160, 0, mk(0,0,0,0,!SC,0,scv(2),scv(1),SC), "r2_end");
      cyc(0, 0, 300, 200, 160, 0, mk(0,0,0,0,0,!SC,scv(2),scv(1),SC), "after_end");
      cyc(0, 1, 300, 200, 160, 0, mk(0,0,0,0,0,!SC,scv(2),scv(1),SC), "after_end_tick");

      // Reset clears scores; then reset on the tick that would end a hold.
      cyc(1, 0, 300, 200, 160, 0, mk(0,0,0,0,0,0,0,0,0), "reset_clears");
      cyc(0, 1, 300, 200, 160, 0, mk(0,0,0,0,1,0,0,0,0), "serve_again");
      cyc(0, 0, 300, 200, 160, 0, mk(0,0,0,0,0,1,0,0,0), "play_again");
      cyc(0, 1, 1020, 200, 300, 0, mk(0,0,1,0,0,0,0,scv(1),0), "miss_left2");
      cyc(0, 1, 300, 200, 160, 0, mk(0,0,0,0,0,0,0,scv(1),0), "h_tick1");
      cyc(0, 1, 300, 200, 160, 0, mk(0,0,0,0,0,0,0,scv(1),0), "h_tick2");
      cyc(1, 1, 300, 200, 160, 0, mk(0,0,0,0,0,0,0,0,0), "reset_on_last_tick");
      cyc(0, 0, 300, 200, 160, 0, mk(0,0,0,0,0,0,0,0,0), "no_pending_serve");
      cyc(0, 1, 300, 200, 160, 0, mk(0,0,0,0,1,0,0,0,0), "idle_then_serve");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
